pcie_io_tx_engine: RTL and testbench
====================================

# pcie_io_tx_engine

Completion generator for the PCIe PIO path: sits directly downstream of the PIO RX engine and the memory request port. It consumes the RX engine's response-type flags, the captured request header fields and the memory response. It emits Completion TLPs on the core's 64-bit AXI-Stream TX interface, then pulses `o_compl_done` so the RX engine accepts the next TLP. It supports single-DW completions only: memory/IO read → CplD, IO write → Cpl, memory write → no TLP.

## Interface
Parameters:
- `C_DATA_WIDTH`, 64, TX stream width; only 64 is supported.
- `KEEP_WIDTH`, `C_DATA_WIDTH/8`, width of `tkeep`.

Ports:
- `i_clk`  in  1  system bus clock
- `i_nrst`  in  1  reset, asynchronous, active-low
- `i_s_axis_tx_tready`  in  1  core accepts the current beat
- `o_s_axis_tx_tdata`  out  64  TLP beat data; DW0 occupies [31:0]
- `o_s_axis_tx_tkeep`  out  8  byte valid
- `o_s_axis_tx_tlast`  out  1  last beat of the TLP
- `o_s_axis_tx_tvalid`  out  1  beat valid
- `o_s_axis_tx_tuser`  out  4  driven constant 0
- `i_tx_ena`, `i_tx_completion`, `i_tx_with_data`  in  1 each  response-type flags from the RX engine, held until `o_compl_done`
- `o_compl_done`  out  1  one-cycle pulse: response finished
- `i_req_tc`  in  3  request field, stable while `i_tx_ena`=1
- `i_req_td`  in  1  request field
- `i_req_ep`  in  1  request field
- `i_req_attr`  in  2  request field
- `i_req_rid`  in  16  requester ID
- `i_req_tag`  in  8  request tag
- `i_req_be`  in  8  byte enables
- `i_req_addr`  in  `CFG_PCIE_DMAADDR_WIDTH`  request address
- `i_completer_id`  in  16  {bus, dev, func} from the core config space
- `i_resp_mem_valid`  in  1  memory read/write response
- `i_resp_mem_data`  in  64  memory read data
- `i_resp_mem_fault`  in  1  access error; used only with the `_EN` macro

## Operation
States: IDLE, WAIT_RESP, BEAT0, BEAT1, DONE, RELEASE.
- `resp_seen` is a sticky register. It is set by `i_resp_mem_valid` in any state except BEAT0/BEAT1/DONE and cleared on entering DONE. On the capturing cycle it latches `i_resp_mem_data` and `i_resp_mem_fault`.
- IDLE, `i_tx_ena`=1 → WAIT_RESP, or straight to BEAT0/DONE if `resp_seen` is already set (response arrived first).
- WAIT_RESP, `resp_seen` or `i_resp_mem_valid`:
  - `i_tx_completion|i_tx_with_data` → BEAT0.
  - Otherwise (posted write) → DONE.
- Header fields:
  - DW0 = {1'b0, fmt_type, 1'b0, tc, 4'b0, td, ep, attr, 2'b0, len}.
  - DW1 = {completer_id, status, 1'b0, byte_count[11:0]}.
  - DW2 = {rid, tag, 1'b0, lower_addr[6:0]}.
- CplD (`i_tx_with_data`):
  - fmt_type 7'h4A, len 1, status 3'b000.
  - Payload DW = `i_req_addr[2]` ? data[63:32] : data[31:0].
  - byte_count from `be[3:0]`: 1xx1→4; 01x1 or 1x10→3; 0011/0110/1100→2; single bit or 0000→1.
  - lower_addr = `i_req_addr[6:0]`; bits [1:0] are already byte-adjusted upstream.
- Cpl (`i_tx_completion` only): fmt_type 7'h0A, len 0, byte_count 4, lower_addr 0, status SC.
- BEAT0: data {DW1, DW0}, tkeep FF, tlast 0. Held until `tready`, then → BEAT1.
- BEAT1:
  - CplD: data {payload, DW2}, tkeep FF.
  - Cpl: data {32'h0, DW2}, tkeep 0F.
  - tlast 1. On `tready` → DONE.
- DONE: `o_compl_done`=1 for one cycle, → RELEASE.
- RELEASE: wait for `i_tx_ena`=0 → IDLE. This prevents re-triggering on the flags still held for one cycle.

## Timing
- Reset values:
  - tvalid, tlast, `o_compl_done`: 0.
  - tdata, tkeep, tuser: 0.
  - State IDLE, `resp_seen` 0.
- All outputs are registered. A response on cycle N in WAIT_RESP gives tvalid=1 at N+1.
- With `tready` held at 1: BEAT1 at N+2, `o_compl_done` at N+3.
- Posted write: `o_compl_done` at N+2.
- tdata, tkeep and tlast are stable while tvalid=1 and `tready`=0. tvalid never drops before acceptance.
- Header fields are latched on the IDLE→WAIT_RESP transition.
- Reset mid-TLP aborts the TLP immediately; tvalid drops asynchronously.

## Configuration
- `PCIE_IO_TX_UR_EN` defined:
  - A latched fault turns a CplD into a Cpl with status 3'b001 (UR): len 0, byte_count 4, no payload.
  - A latched fault on an IO write sets status UR.
- Not defined: `i_resp_mem_fault` is ignored and status is always SC.

## Structure
- Add to `pcie_cfg_pkg`:
  - The fmt_type constants (CPL 7'h0A, CPLD 7'h4A) and the status codes (SC, UR).
  - The state encoding.
  - A `pcie_cpl_byte_count(be[3:0])` function.
- No sub-module: a single registered comb/ff pair.

## Test plan
- Read, be=8'h0F, addr=34'h0_8000_0010, data=64'h1111_2222_3333_4444:
  - BEAT0 DW0=32'h4A00_0001; DW1 byte_count 4.
  - BEAT1 {32'h3333_4444, DW2 with lower_addr 7'h10}, tkeep FF, tlast.
  - `o_compl_done` one pulse.
- IO write, be=8'h03 → Cpl: DW0=32'h0A00_0000, DW1[11:0]=4, BEAT1 tkeep 0F, tlast.
- Posted write (`i_tx_ena` only) → no tvalid ever; `o_compl_done` 2 cycles after `i_resp_mem_valid`.
- `tready` low for 5 cycles during BEAT0 and BEAT1 → beats held unchanged, no duplicates, exactly one done pulse.
- Response one cycle before `i_tx_ena` → `resp_seen` is used and the CplD carries the latched data.
- With `PCIE_IO_TX_UR_EN` and fault=1 on a read → Cpl, DW1 status 3'b001, 2 beats, tkeep 0F on BEAT1.

Source files
------------

// File: rtl/pcie_cfg_pkg.sv
// Shared PCIe PIO configuration: address width, completion TLP constants,
// TX engine state encoding and the completion byte-count helper.
package pcie_cfg_pkg;

  localparam int CFG_PCIE_DMAADDR_WIDTH = 34;

  localparam logic [6:0] PCIE_FMT_CPL  = 7'h0A;
  localparam logic [6:0] PCIE_FMT_CPLD = 7'h4A;

  localparam logic [2:0] PCIE_CPL_SC = 3'b000;
  localparam logic [2:0] PCIE_CPL_UR = 3'b001;

  typedef enum logic [2:0] {
    TX_IDLE      = 3'd0,
    TX_WAIT_RESP = 3'd1,
    TX_BEAT0     = 3'd2,
    TX_BEAT1     = 3'd3,
    TX_DONE      = 3'd4,
    TX_RELEASE   = 3'd5
  } tx_state_t;

  // Byte count of a single-DW read from its first-DW byte enables.
  function automatic logic [11:0] pcie_cpl_byte_count(input logic [3:0] be);
    logic [11:0] bc;
    casez (be)
      4'b1??1:                   bc = 12'd4;
      4'b01?1, 4'b1?10:          bc = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bc = 12'd2;
      default:                   bc = 12'd1;
    endcase
    return bc;
  endfunction

endpackage

// File: rtl/pcie_io_tx_engine.sv
// PIO completion generator: builds single-DW Cpl/CplD TLPs on the 64-bit TX stream.
// Optional macro PCIE_IO_TX_UR_EN: memory faults turn the completion into UR.
//
// state      | meaning
// IDLE       | waiting for the RX engine to request a response
// WAIT_RESP  | header captured, waiting for the memory response
// BEAT0      | presenting {DW1, DW0} until accepted
// BEAT1      | presenting {payload/0, DW2} with tlast until accepted
// DONE       | o_compl_done pulse
// RELEASE    | waiting for i_tx_ena to drop before re-arming
module pcie_io_tx_engine
  import pcie_cfg_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                              i_clk,
  input  logic                              i_nrst,
  input  logic                              i_s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0]           o_s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]             o_s_axis_tx_tkeep,
  output logic                              o_s_axis_tx_tlast,
  output logic                              o_s_axis_tx_tvalid,
  output logic [3:0]                        o_s_axis_tx_tuser,
  input  logic                              i_tx_ena,
  input  logic                              i_tx_completion,
  input  logic                              i_tx_with_data,
  output logic                              o_compl_done,
  input  logic [2:0]                        i_req_tc,
  input  logic                              i_req_td,
  input  logic                              i_req_ep,
  input  logic [1:0]                        i_req_attr,
  input  logic [15:0]                       i_req_rid,
  input  logic [7:0]                        i_req_tag,
  input  logic [7:0]                        i_req_be,
  input  logic [CFG_PCIE_DMAADDR_WIDTH-1:0] i_req_addr,
  input  logic [15:0]                       i_completer_id,
  input  logic                              i_resp_mem_valid,
  input  logic [63:0]                       i_resp_mem_data,
  input  logic                              i_resp_mem_fault
);

  tx_state_t   state;
  logic        resp_seen;
  logic [63:0] resp_data_q;
  logic [2:0]  tc_q;
  logic        td_q;
  logic        ep_q;
  logic [1:0]  attr_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [3:0]  be_q;
  logic [6:0]  la_q;
  logic [63:0] beat1_q;
  logic [7:0]  keep1_q;

  logic        idle;
  logic        capture_ok;
  logic        resp_ready;
  logic        needs_tlp;
  logic [2:0]  h_tc;
  logic        h_td;
  logic        h_ep;
  logic [1:0]  h_attr;
  logic [15:0] h_rid;
  logic [7:0]  h_tag;
  logic [3:0]  h_be;
  logic [6:0]  h_la;
  logic [63:0] r_data;
  logic        cpld;
  logic [2:0]  status;
  logic [6:0]  fmt;
  logic [9:0]  len;
  logic [11:0] byte_cnt;
  logic [6:0]  lower_addr;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [31:0] payload;
  logic [63:0] beat0;
  logic [63:0] beat1;
  logic [7:0]  keep1;

`ifdef PCIE_IO_TX_UR_EN
  logic resp_fault_q;
  logic r_fault;
  logic unused_inputs;
  assign unused_inputs = ^{i_req_be[7:4], i_req_addr[CFG_PCIE_DMAADDR_WIDTH-1:7]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_req_be[7:4], i_req_addr[CFG_PCIE_DMAADDR_WIDTH-1:7],
                           i_resp_mem_fault};
`endif

  assign o_s_axis_tx_tuser = 4'd0;

  // In IDLE the header is being latched this very cycle, so read it live.
  always_comb begin
    idle       = (state == TX_IDLE);
    capture_ok = (state != TX_BEAT0) && (state != TX_BEAT1) && (state != TX_DONE);
    resp_ready = (idle && i_tx_ena && resp_seen) ||
                 ((state == TX_WAIT_RESP) && (resp_seen || i_resp_mem_valid));
    needs_tlp  = i_tx_completion | i_tx_with_data;
    h_tc       = idle ? i_req_tc          : tc_q;
    h_td       = idle ? i_req_td          : td_q;
    h_ep       = idle ? i_req_ep          : ep_q;
    h_attr     = idle ? i_req_attr        : attr_q;
    h_rid      = idle ? i_req_rid         : rid_q;
    h_tag      = idle ? i_req_tag         : tag_q;
    h_be       = idle ? i_req_be[3:0]     : be_q;
    h_la       = idle ? i_req_addr[6:0]   : la_q;
    r_data     = resp_seen ? resp_data_q : i_resp_mem_data;
    cpld       = i_tx_with_data;
    status     = PCIE_CPL_SC;
`ifdef PCIE_IO_TX_UR_EN
    r_fault    = resp_seen ? resp_fault_q : i_resp_mem_fault;
    if (r_fault) begin
      cpld   = 1'b0;
      status = PCIE_CPL_UR;
    end
`endif
    fmt        = cpld ? PCIE_FMT_CPLD : PCIE_FMT_CPL;
    len        = cpld ? 10'd1 : 10'd0;
    byte_cnt   = cpld ? pcie_cpl_byte_count(h_be) : 12'd4;
    lower_addr = cpld ? h_la : 7'd0;
    dw0        = {1'b0, fmt, 1'b0, h_tc, 4'b0, h_td, h_ep, h_attr, 2'b0, len};
    dw1        = {i_completer_id, status, 1'b0, byte_cnt};
    dw2        = {h_rid, h_tag, 1'b0, lower_addr};
    payload    = h_la[2] ? r_data[63:32] : r_data[31:0];
    beat0      = {dw1, dw0};
    beat1      = cpld ? {payload, dw2} : {32'h0, dw2};
    keep1      = cpld ? 8'hFF : 8'h0F;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state              <= TX_IDLE;
      resp_seen          <= 1'b0;
      resp_data_q        <= '0;
      tc_q               <= '0;
      td_q               <= 1'b0;
      ep_q               <= 1'b0;
      attr_q             <= '0;
      rid_q              <= '0;
      tag_q              <= '0;
      be_q               <= '0;
      la_q               <= '0;
      beat1_q            <= '0;
      keep1_q            <= '0;
      o_s_axis_tx_tdata  <= '0;
      o_s_axis_tx_tkeep  <= '0;
      o_s_axis_tx_tlast  <= 1'b0;
      o_s_axis_tx_tvalid <= 1'b0;
      o_compl_done       <= 1'b0;
`ifdef PCIE_IO_TX_UR_EN
      resp_fault_q       <= 1'b0;
`endif
    end else begin
      o_compl_done <= 1'b0;

      if (capture_ok && i_resp_mem_valid && !resp_seen) begin
        resp_seen   <= 1'b1;
        resp_data_q <= i_resp_mem_data;
`ifdef PCIE_IO_TX_UR_EN
        resp_fault_q <= i_resp_mem_fault;
`endif
      end

      case (state)
        TX_IDLE: begin
          if (i_tx_ena) begin
            tc_q   <= i_req_tc;
            td_q   <= i_req_td;
            ep_q   <= i_req_ep;
            attr_q <= i_req_attr;
            rid_q  <= i_req_rid;
            tag_q  <= i_req_tag;
            be_q   <= i_req_be[3:0];
            la_q   <= i_req_addr[6:0];
            state  <= TX_WAIT_RESP;
          end
        end
        TX_WAIT_RESP: ;
        TX_BEAT0: begin
          if (i_s_axis_tx_tready) begin
            o_s_axis_tx_tdata <= beat1_q;
            o_s_axis_tx_tkeep <= keep1_q;
            o_s_axis_tx_tlast <= 1'b1;
            state             <= TX_BEAT1;
          end
        end
        TX_BEAT1: begin
          if (i_s_axis_tx_tready) begin
            o_s_axis_tx_tvalid <= 1'b0;
            o_s_axis_tx_tlast  <= 1'b0;
            o_s_axis_tx_tdata  <= '0;
            o_s_axis_tx_tkeep  <= '0;
            o_compl_done       <= 1'b1;
            resp_seen          <= 1'b0;
            state              <= TX_DONE;
          end
        end
        // Entered from BEAT1 the pulse is already out; from a posted write it is not.
        TX_DONE: begin
          o_compl_done <= !o_compl_done;
          state        <= TX_RELEASE;
        end
        TX_RELEASE: begin
          if (!i_tx_ena) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase

      if (resp_ready) begin
        if (needs_tlp) begin
          o_s_axis_tx_tvalid <= 1'b1;
          o_s_axis_tx_tdata  <= beat0;
          o_s_axis_tx_tkeep  <= 8'hFF;
          o_s_axis_tx_tlast  <= 1'b0;
          beat1_q            <= beat1;
          keep1_q            <= keep1;
          state              <= TX_BEAT0;
        end else begin
          resp_seen <= 1'b0;
          state     <= TX_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_io_tx_engine.sv
// Directed bench for pcie_io_tx_engine; fault expectations follow PCIE_IO_TX_UR_EN.
module tb_pcie_io_tx_engine;
  import pcie_cfg_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_s_axis_tx_tready = 1'b1;
  logic [63:0] o_s_axis_tx_tdata;
  logic [7:0]  o_s_axis_tx_tkeep;
  logic        o_s_axis_tx_tlast;
  logic        o_s_axis_tx_tvalid;
  logic [3:0]  o_s_axis_tx_tuser;
  logic        i_tx_ena = 1'b0;
  logic        i_tx_completion = 1'b0;
  logic        i_tx_with_data = 1'b0;
  logic        o_compl_done;
  logic [2:0]  i_req_tc = '0;
  logic        i_req_td = 1'b0;
  logic        i_req_ep = 1'b0;
  logic [1:0]  i_req_attr = '0;
  logic [15:0] i_req_rid = '0;
  logic [7:0]  i_req_tag = '0;
  logic [7:0]  i_req_be = '0;
  logic [CFG_PCIE_DMAADDR_WIDTH-1:0] i_req_addr = '0;
  logic [15:0] i_completer_id = 16'h0100;
  logic        i_resp_mem_valid = 1'b0;
  logic [63:0] i_resp_mem_data = '0;
  logic        i_resp_mem_fault = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_beats  = 0;
  int n_done   = 0;

  pcie_io_tx_engine dut (
    .i_clk              (i_clk),
    .i_nrst             (i_nrst),
    .i_s_axis_tx_tready (i_s_axis_tx_tready),
    .o_s_axis_tx_tdata  (o_s_axis_tx_tdata),
    .o_s_axis_tx_tkeep  (o_s_axis_tx_tkeep),
    .o_s_axis_tx_tlast  (o_s_axis_tx_tlast),
    .o_s_axis_tx_tvalid (o_s_axis_tx_tvalid),
    .o_s_axis_tx_tuser  (o_s_axis_tx_tuser),
    .i_tx_ena           (i_tx_ena),
    .i_tx_completion    (i_tx_completion),
    .i_tx_with_data     (i_tx_with_data),
    .o_compl_done       (o_compl_done),
    .i_req_tc           (i_req_tc),
    .i_req_td           (i_req_td),
    .i_req_ep           (i_req_ep),
    .i_req_attr         (i_req_attr),
    .i_req_rid          (i_req_rid),
    .i_req_tag          (i_req_tag),
    .i_req_be           (i_req_be),
    .i_req_addr         (i_req_addr),
    .i_completer_id     (i_completer_id),
    .i_resp_mem_valid   (i_resp_mem_valid),
    .i_resp_mem_data    (i_resp_mem_data),
    .i_resp_mem_fault   (i_resp_mem_fault)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (i_nrst && o_s_axis_tx_tvalid && i_s_axis_tx_tready) n_beats++;
    if (i_nrst && o_compl_done) n_done++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic cpl, input logic wd, input logic [2:0] tc,
                         input logic td, input logic ep, input logic [1:0] attr,
                         input logic [15:0] rid, input logic [7:0] tag,
                         input logic [7:0] be, input logic [33:0] addr);
    i_tx_completion = cpl;
    i_tx_with_data  = wd;
    i_req_tc        = tc;
    i_req_td        = td;
    i_req_ep        = ep;
    i_req_attr      = attr;
    i_req_rid       = rid;
    i_req_tag       = tag;
    i_req_be        = be;
    i_req_addr      = addr;
  endtask

  // Called at the negedge where i_tx_ena was raised; response arrives next cycle.
  task automatic run_cpl(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [7:0] k1);
    int beats0, done0;
    beats0 = n_beats;
    done0  = n_done;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b0;
    chk({tag, "_b0_valid"}, 64'(o_s_axis_tx_tvalid), 64'd1);
    chk({tag, "_b0_data"}, o_s_axis_tx_tdata, b0);
    chk({tag, "_b0_keep"}, 64'(o_s_axis_tx_tkeep), 64'hFF);
    chk({tag, "_b0_last"}, 64'(o_s_axis_tx_tlast), 64'd0);
    @(negedge i_clk);
    chk({tag, "_b1_valid"}, 64'(o_s_axis_tx_tvalid), 64'd1);
    chk({tag, "_b1_data"}, o_s_axis_tx_tdata, b1);
    chk({tag, "_b1_keep"}, 64'(o_s_axis_tx_tkeep), 64'(k1));
    chk({tag, "_b1_last"}, 64'(o_s_axis_tx_tlast), 64'd1);
    @(negedge i_clk);
    chk({tag, "_done"}, 64'(o_compl_done), 64'd1);
    chk({tag, "_valid_off"}, 64'(o_s_axis_tx_tvalid), 64'd0);
    @(negedge i_clk);
    chk({tag, "_done_off"}, 64'(o_compl_done), 64'd0);
    i_tx_ena = 1'b0;
    @(negedge i_clk);
    chk({tag, "_beats"}, 64'(n_beats - beats0), 64'd2);
    chk({tag, "_ndone"}, 64'(n_done - done0), 64'd1);
  endtask

  initial begin
    int beats0, done0;
    #12;
    chk("rst_valid", 64'(o_s_axis_tx_tvalid), 64'd0);
    chk("rst_last", 64'(o_s_axis_tx_tlast), 64'd0);
    chk("rst_done", 64'(o_compl_done), 64'd0);
    chk("rst_data", o_s_axis_tx_tdata, 64'd0);
    chk("rst_keep", 64'(o_s_axis_tx_tkeep), 64'd0);
    chk("rst_user", 64'(o_s_axis_tx_tuser), 64'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);

    // Memory read, DW-aligned low half
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'hABCD, 8'h12, 8'h0F, 34'h0_8000_0010);
    i_resp_mem_data = 64'h1111_2222_3333_4444;
    i_tx_ena = 1'b1;
    run_cpl("rd", {32'h0100_0004, 32'h4A00_0001}, 64'h3333_4444_ABCD_1210, 8'hFF);

    // IO write completion
    set_req(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 16'h1234, 8'h05, 8'h03, 34'h0_0000_0004);
    i_tx_ena = 1'b1;
    run_cpl("iowr", {32'h0100_0004, 32'h0A00_0000}, 64'h0000_0000_1234_0500, 8'h0F);

    // Posted write: no TLP, done two cycles after the response
    beats0 = n_beats;
    done0  = n_done;
    set_req(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0, 8'h0, 8'h0F, 34'h0);
    i_tx_ena = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b0;
    chk("pw_done_n1", 64'(o_compl_done), 64'd0);
    chk("pw_valid_n1", 64'(o_s_axis_tx_tvalid), 64'd0);
    @(negedge i_clk);
    chk("pw_done_n2", 64'(o_compl_done), 64'd1);
    chk("pw_valid_n2", 64'(o_s_axis_tx_tvalid), 64'd0);
    @(negedge i_clk);
    chk("pw_done_off", 64'(o_compl_done), 64'd0);
    i_tx_ena = 1'b0;
    @(negedge i_clk);
    chk("pw_beats", 64'(n_beats - beats0), 64'd0);
    chk("pw_ndone", 64'(n_done - done0), 64'd1);

    // Back-pressure on both beats, upper payload half, non-zero header fields
    beats0 = n_beats;
    done0  = n_done;
    set_req(1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 2'b10, 16'h5678, 8'h9A, 8'h06, 34'h0_0000_0024);
    i_resp_mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
    i_s_axis_tx_tready = 1'b0;
    i_tx_ena = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_b0_valid", 64'(o_s_axis_tx_tvalid), 64'd1);
      chk("st_b0_data", o_s_axis_tx_tdata, {32'h0100_0002, 32'h4A50_A001});
      chk("st_b0_last", 64'(o_s_axis_tx_tlast), 64'd0);
      @(negedge i_clk);
    end
    i_s_axis_tx_tready = 1'b1;
    @(negedge i_clk);
    i_s_axis_tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_b1_valid", 64'(o_s_axis_tx_tvalid), 64'd1);
      chk("st_b1_data", o_s_axis_tx_tdata, 64'hAAAA_BBBB_5678_9A24);
      chk("st_b1_last", 64'(o_s_axis_tx_tlast), 64'd1);
      chk("st_no_done", 64'(o_compl_done), 64'd0);
      @(negedge i_clk);
    end
    i_s_axis_tx_tready = 1'b1;
    @(negedge i_clk);
    chk("st_done", 64'(o_compl_done), 64'd1);
    @(negedge i_clk);
    i_tx_ena = 1'b0;
    @(negedge i_clk);
    chk("st_beats", 64'(n_beats - beats0), 64'd2);
    chk("st_ndone", 64'(n_done - done0), 64'd1);

    // Response arrives before i_tx_ena; later data changes must not leak in
    beats0 = n_beats;
    i_resp_mem_data  = 64'hDEAD_BEEF_CAFE_F00D;
    i_resp_mem_valid = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b0;
    i_resp_mem_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0001, 8'h77, 8'h01, 34'h0_0000_0008);
    i_tx_ena = 1'b1;
    @(negedge i_clk);
    chk("early_b0_valid", 64'(o_s_axis_tx_tvalid), 64'd1);
    chk("early_b0_data", o_s_axis_tx_tdata, {32'h0100_0001, 32'h4A00_0001});
    @(negedge i_clk);
    chk("early_b1_data", o_s_axis_tx_tdata, 64'hCAFE_F00D_0001_7708);
    @(negedge i_clk);
    chk("early_done", 64'(o_compl_done), 64'd1);
    @(negedge i_clk);
    i_tx_ena = 1'b0;
    @(negedge i_clk);
    chk("early_beats", 64'(n_beats - beats0), 64'd2);

    // Faulting read, be 0111 -> byte count 3
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0002, 8'h03, 8'h07, 34'h0_0000_000C);
    i_resp_mem_data  = 64'h0123_4567_89AB_CDEF;
    i_resp_mem_fault = 1'b1;
    i_tx_ena = 1'b1;
`ifdef PCIE_IO_TX_UR_EN
    run_cpl("flt", {32'h0100_2004, 32'h0A00_0000}, 64'h0000_0000_0002_0300, 8'h0F);
`else
    run_cpl("flt", {32'h0100_0003, 32'h4A00_0001}, 64'h0123_4567_0002_030C, 8'hFF);
`endif
    i_resp_mem_fault = 1'b0;

    // Reset in the middle of a TLP
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h4444, 8'h01, 8'h0F, 34'h0);
    i_s_axis_tx_tready = 1'b0;
    i_tx_ena = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b1;
    @(negedge i_clk);
    i_resp_mem_valid = 1'b0;
    chk("mid_valid_pre", 64'(o_s_axis_tx_tvalid), 64'd1);
    #2 i_nrst = 1'b0;
    #1;
    chk("mid_valid_rst", 64'(o_s_axis_tx_tvalid), 64'd0);
    chk("mid_keep_rst", 64'(o_s_axis_tx_tkeep), 64'd0);
    chk("mid_data_rst", o_s_axis_tx_tdata, 64'd0);
    i_tx_ena = 1'b0;
    i_s_axis_tx_tready = 1'b1;
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("mid_idle_valid", 64'(o_s_axis_tx_tvalid), 64'd0);
    chk("mid_idle_done", 64'(o_compl_done), 64'd0);

    // Clean read after the abort
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'hABCD, 8'h12, 8'h0F, 34'h0_8000_0014);
    i_resp_mem_data = 64'h1111_2222_3333_4444;
    i_tx_ena = 1'b1;
    run_cpl("rd2", {32'h0100_0004, 32'h4A00_0001}, 64'h1111_2222_ABCD_1214, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
